aes_decrypt_iter: RTL and testbench

AES_DECRYPT_ITER -- requirements
Module: aes_decrypt_iter

---
 rtl/aes_pkg.sv | 117 +++++++++++
 rtl/aes_decrypt_key_sched.sv | 31 +++
 rtl/aes_decrypt_iter.sv | 137 +++++++++++++
 tb/tb_aes_decrypt_iter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 decryption helpers: S-box pair, Rcon, GF(2^8) arithmetic,
// inverse round transforms and the controller state encoding.
package aes_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_KEY_FWD = 3'd1,
      S_INIT    = 3'd2,
      S_ROUND   = 3'd3,
      S_DONE    = 3'd4
   } state_e;

   localparam logic KS_FWD = 1'b0;
   localparam logic KS_INV = 1'b1;

   localparam logic [7:0] RCON [0:10] = '{
      8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
      8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   function automatic logic [7:0] rcon(input logic [3:0] idx);
      return (idx <= 4'd10) ? RCON[idx] : 8'h00;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254; zero maps to zero as AES requires.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] p;
      logic [7:0] acc;
      p   = a;
      acc = 8'h01;
      for (int i = 1; i < 8; i++) begin
         p   = gf_mul(p, p);
         acc = gf_mul(acc, p);
      end
      return acc;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      logic [15:0] d;
      d = {x, x};
      return d[15-n -: 8];
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] v;
      v = gf_inv(x);
      return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] x);
      return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   // Byte i of a block, byte 0 in the top bits; column-major (index = 4*col + row).
   function automatic logic [7:0] get_byte(input logic [127:0] s, input int i);
      return s[127-8*i -: 8];
   endfunction

   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = s;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = get_byte(s, 4*((c - r) & 3) + r);
      return o;
   endfunction

   function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
      logic [127:0] o;
      o = s;
      for (int i = 0; i < 16; i++)
         o[127-8*i -: 8] = inv_sbox(get_byte(s, i));
      return o;
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = s;
      for (int c = 0; c < 4; c++) begin
         a0 = get_byte(s, 4*c);
         a1 = get_byte(s, 4*c+1);
         a2 = get_byte(s, 4*c+2);
         a3 = get_byte(s, 4*c+3);
         o[127-32*c -: 8]  = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
         o[119-32*c -: 8]  = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
         o[111-32*c -: 8]  = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
         o[103-32*c -: 8]  = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
      end
      return o;
   endfunction

endpackage

// File: rtl/aes_decrypt_key_sched.sv
// One AES-128 key-schedule step: forward (rk[i-1] -> rk[i]) or inverse
// (rk[i] -> rk[i-1]), with i given by the round index.
module aes_decrypt_key_sched
   import aes_pkg::*;
(
   input  logic         mode,
   input  logic [3:0]   round,
   input  logic [127:0] key_in,
   output logic [127:0] key_out
);

   logic [31:0] w0, w1, w2, w3;
   logic [31:0] t;
   logic [31:0] n0;

   // Both directions share one SubWord: the inverse step needs the recovered
   // last word of the previous key, which is simply w3 ^ w2.
   always_comb begin
      w0 = key_in[127:96];
      w1 = key_in[95:64];
      w2 = key_in[63:32];
      w3 = key_in[31:0];
      t  = sub_word(rot_word((mode == KS_INV) ? (w3 ^ w2) : w3)) ^ {rcon(round), 24'h000000};
      n0 = w0 ^ t;
      if (mode == KS_FWD)
         key_out = {n0, n0 ^ w1, n0 ^ w1 ^ w2, n0 ^ w1 ^ w2 ^ w3};
      else
         key_out = {n0, w0 ^ w1, w1 ^ w2, w2 ^ w3};
   end

endmodule

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryptor, one round per clock. Define AES_DEC_KEY_CACHE_EN
// to keep the last key and its round-10 key so repeated keys skip expansion.
module aes_decrypt_iter
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         reset_n,
   input  logic [127:0] cipher_text,
   input  logic [127:0] cipher_key,
   input  logic         decipher_new_en,
   output logic         decipher_busy,
   output logic         decipher_ready,
   output logic [127:0] plain_text
);

   state_e       state;
   logic [127:0] state_q;
   logic [127:0] key_q;
   logic [3:0]   rnd_q;
   logic [127:0] ks_out;
   logic         ks_mode;
   logic [127:0] arked;
   logic [127:0] round_out;
   logic         cache_hit;
   logic [127:0] cached_rk;

   assign ks_mode = (state == S_KEY_FWD) ? KS_FWD : KS_INV;

   aes_decrypt_key_sched u_key_sched (
      .mode    (ks_mode),
      .round   (rnd_q),
      .key_in  (key_q),
      .key_out (ks_out)
   );

   always_comb begin
      arked     = inv_sub_bytes(inv_shift_rows(state_q)) ^ key_q;
      round_out = (rnd_q == 4'd0) ? arked : inv_mix_columns(arked);
   end

`ifdef AES_DEC_KEY_CACHE_EN
   logic [127:0] cache_key;
   logic [127:0] cache_rk;
   logic         cache_valid;
   logic         accept;

   assign accept    = decipher_new_en && ((state == S_IDLE) || (state == S_DONE));
   assign cache_hit = cache_valid && (cache_key == cipher_key);
   assign cached_rk = cache_rk;

   // A miss claims the entry at once; it only becomes valid when expansion ends.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cache_key   <= '0;
         cache_rk    <= '0;
         cache_valid <= 1'b0;
      end else begin
         if (accept && !cache_hit) begin
            cache_key   <= cipher_key;
            cache_valid <= 1'b0;
         end
         if ((state == S_KEY_FWD) && (rnd_q == 4'd10)) begin
            cache_rk    <= ks_out;
            cache_valid <= 1'b1;
         end
      end
   end
`else
   assign cache_hit = 1'b0;
   assign cached_rk = '0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= S_IDLE;
         state_q        <= '0;
         key_q          <= '0;
         rnd_q          <= '0;
         plain_text     <= '0;
         decipher_ready <= 1'b0;
         decipher_busy  <= 1'b0;
      end else begin
         decipher_ready <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (decipher_new_en) begin
                  state_q       <= cipher_text;
                  decipher_busy <= 1'b1;
                  if (cache_hit) begin
                     key_q <= cached_rk;
                     rnd_q <= 4'd10;
                     state <= S_INIT;
                  end else begin
                     key_q <= cipher_key;
                     rnd_q <= 4'd1;
                     state <= S_KEY_FWD;
                  end
               end else begin
                  decipher_busy <= 1'b0;
                  state         <= S_IDLE;
               end
            end
            S_KEY_FWD: begin
               key_q <= ks_out;
               if (rnd_q == 4'd10)
                  state <= S_INIT;
               else
                  rnd_q <= rnd_q + 4'd1;
            end
            S_INIT: begin
               // rnd_q is 10 here, so the inverse step yields rk9.
               state_q <= state_q ^ key_q;
               key_q   <= ks_out;
               rnd_q   <= 4'd9;
               state   <= S_ROUND;
            end
            S_ROUND: begin
               state_q <= round_out;
               key_q   <= ks_out;
               if (rnd_q == 4'd0) begin
                  plain_text     <= round_out;
                  decipher_ready <= 1'b1;
                  decipher_busy  <= 1'b0;
                  state          <= S_DONE;
               end else begin
                  rnd_q <= rnd_q - 4'd1;
               end
            end
            default: begin
               decipher_busy <= 1'b0;
               state         <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Self-checking bench for aes_decrypt_iter using FIPS-197 vectors and a
// scoreboard of expected plaintexts and latencies.
module tb_aes_decrypt_iter;

   logic         clk;
   logic         reset_n;
   logic [127:0] cipher_text;
   logic [127:0] cipher_key;
   logic         decipher_new_en;
   logic         decipher_busy;
   logic         decipher_ready;
   logic [127:0] plain_text;

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

`ifdef AES_DEC_KEY_CACHE_EN
   localparam bit CACHE_ON = 1'b1;
`else
   localparam bit CACHE_ON = 1'b0;
`endif

   int           vectors = 0;
   int           miscompares = 0;
   logic [127:0] exp_q[$];
   int           lat_q[$];
   logic [127:0] tb_cache_key = '0;
   bit           tb_cache_valid = 1'b0;

   aes_decrypt_iter dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .cipher_text     (cipher_text),
      .cipher_key      (cipher_key),
      .decipher_new_en (decipher_new_en),
      .decipher_busy   (decipher_busy),
      .decipher_ready  (decipher_ready),
      .plain_text      (plain_text)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Caller is at a negedge with the DUT in IDLE or DONE; returns one negedge
   // after the accepting edge (edge 0) with garbage on the data inputs.
   task automatic send(input logic [127:0] ct, input logic [127:0] key, input logic [127:0] pt);
      bit hit;
      hit = CACHE_ON && tb_cache_valid && (key == tb_cache_key);
      exp_q.push_back(pt);
      lat_q.push_back(hit ? 11 : 21);
      if (!hit) begin
         tb_cache_key   = key;
         tb_cache_valid = CACHE_ON;
      end
      decipher_new_en = 1'b1;
      cipher_text     = ct;
      cipher_key      = key;
      @(negedge clk);
      decipher_new_en = 1'b0;
      cipher_text     = {$urandom, $urandom, $urandom, $urandom};
      cipher_key      = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic wait_ready(input int start, output int lat, output logic [127:0] pt, output bit seen);
      lat  = -1;
      pt   = 'x;
      seen = 1'b0;
      for (int n = start; n <= 40; n++) begin
         if (decipher_ready) begin
            lat  = n;
            pt   = plain_text;
            seen = 1'b1;
            return;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      int lat; logic [127:0] pt; bit seen; logic [127:0] exp_pt; int exp_lat;
      reset_n = 1'b0;
      decipher_new_en = 1'b1;
      cipher_text = C1_CT;
      cipher_key  = C1_KEY;
      repeat (3) @(negedge clk);
      vectors++;
      if (decipher_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", decipher_busy); end
      vectors++;
      if (decipher_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b want 0", decipher_ready); end
      vectors++;
      if (plain_text !== 128'h0) begin miscompares++; $display("FAIL reset_pt: got %h want 0", plain_text); end
      decipher_new_en = 1'b0;
      reset_n = 1'b1;
      send(C1_CT, C1_KEY, C1_PT);
      wait_ready(0, lat, pt, seen);
      exp_pt = exp_q.pop_front();
      exp_lat = lat_q.pop_front();
      vectors++;
      if (!seen || pt !== exp_pt) begin miscompares++; $display("FAIL first_after_reset_pt: got %h want %h", pt, exp_pt); end
      vectors++;
      if (lat !== exp_lat) begin miscompares++; $display("FAIL first_after_reset_lat: got %0d want %0d", lat, exp_lat); end
      @(negedge clk);
   endtask

   task automatic test_fips_c1();
      int lat; logic [127:0] pt; bit seen; logic [127:0] exp_pt; int exp_lat;
      send(C1_CT, C1_KEY, C1_PT);
      vectors++;
      if (decipher_busy !== 1'b1) begin miscompares++; $display("FAIL c1_busy: got %b want 1", decipher_busy); end
      wait_ready(0, lat, pt, seen);
      exp_pt = exp_q.pop_front();
      exp_lat = lat_q.pop_front();
      vectors++;
      if (!seen || pt !== exp_pt) begin miscompares++; $display("FAIL c1_pt: got %h want %h", pt, exp_pt); end
      vectors++;
      if (lat !== exp_lat) begin miscompares++; $display("FAIL c1_lat: got %0d want %0d", lat, exp_lat); end
      vectors++;
      if (decipher_busy !== 1'b0) begin miscompares++; $display("FAIL c1_done_busy: got %b want 0", decipher_busy); end
      @(negedge clk);
      vectors++;
      if (decipher_ready !== 1'b0) begin miscompares++; $display("FAIL c1_ready_width: got %b want 0", decipher_ready); end
      repeat (3) @(negedge clk);
      vectors++;
      if (plain_text !== exp_pt) begin miscompares++; $display("FAIL c1_pt_hold: got %h want %h", plain_text, exp_pt); end
   endtask

   task automatic test_fips_b();
      int lat; logic [127:0] pt; bit seen; logic [127:0] exp_pt; int exp_lat;
      send(B_CT, B_KEY, B_PT);
      wait_ready(0, lat, pt, seen);
      exp_pt = exp_q.pop_front();
      exp_lat = lat_q.pop_front();
      vectors++;
      if (!seen || pt !== exp_pt) begin miscompares++; $display("FAIL b_pt: got %h want %h", pt, exp_pt); end
      vectors++;
      if (lat !== exp_lat) begin miscompares++; $display("FAIL b_lat: got %0d want %0d", lat, exp_lat); end
      @(negedge clk);
   endtask

   task automatic test_busy_ignore();
      int pulses; int first_lat; logic [127:0] got; logic [127:0] exp_pt; int exp_lat;
      pulses = 0;
      first_lat = -1;
      got = 'x;
      send(C1_CT, C1_KEY, C1_PT);
      for (int n = 0; n <= 30; n++) begin
         if (decipher_ready) begin
            pulses++;
            if (first_lat < 0) begin
               first_lat = n;
               got = plain_text;
            end
         end
         decipher_new_en = (n == 4) || (n == 14);
         if (decipher_new_en) begin
            cipher_text = {$urandom, $urandom, $urandom, $urandom};
            cipher_key  = {$urandom, $urandom, $urandom, $urandom};
         end
         @(negedge clk);
      end
      decipher_new_en = 1'b0;
      exp_pt = exp_q.pop_front();
      exp_lat = lat_q.pop_front();
      vectors++;
      if (pulses !== 1) begin miscompares++; $display("FAIL busy_ignore_pulses: got %0d want 1", pulses); end
      vectors++;
      if (got !== exp_pt) begin miscompares++; $display("FAIL busy_ignore_pt: got %h want %h", got, exp_pt); end
      vectors++;
      if (first_lat !== exp_lat) begin miscompares++; $display("FAIL busy_ignore_lat: got %0d want %0d", first_lat, exp_lat); end
   endtask

   task automatic test_reset_mid_op();
      int lat; logic [127:0] pt; bit seen; logic [127:0] exp_pt; int exp_lat; int pulses;
      pulses = 0;
      send(B_CT, B_KEY, B_PT);
      for (int n = 1; n <= 11; n++) begin
         @(negedge clk);
         if (decipher_ready) pulses++;
      end
      @(posedge clk);
      #1 reset_n = 1'b0;
      void'(exp_q.pop_front());
      void'(lat_q.pop_front());
      tb_cache_valid = 1'b0;
      #1;
      vectors++;
      if (plain_text !== 128'h0) begin miscompares++; $display("FAIL midreset_pt: got %h want 0", plain_text); end
      vectors++;
      if (decipher_busy !== 1'b0) begin miscompares++; $display("FAIL midreset_busy: got %b want 0", decipher_busy); end
      vectors++;
      if (decipher_ready !== 1'b0) begin miscompares++; $display("FAIL midreset_ready: got %b want 0", decipher_ready); end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      for (int n = 0; n < 25; n++) begin
         @(negedge clk);
         if (decipher_ready) pulses++;
      end
      vectors++;
      if (pulses !== 0) begin miscompares++; $display("FAIL midreset_no_ready: got %0d pulses want 0", pulses); end
      send(C1_CT, C1_KEY, C1_PT);
      wait_ready(0, lat, pt, seen);
      exp_pt = exp_q.pop_front();
      exp_lat = lat_q.pop_front();
      vectors++;
      if (!seen || pt !== exp_pt) begin miscompares++; $display("FAIL midreset_after_pt: got %h want %h", pt, exp_pt); end
      vectors++;
      if (lat !== exp_lat) begin miscompares++; $display("FAIL midreset_after_lat: got %0d want %0d", lat, exp_lat); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int lat; logic [127:0] pt; bit seen; logic [127:0] exp_pt; int exp_lat; logic [127:0] first_pt;
      send(C1_CT, C1_KEY, C1_PT);
      wait_ready(0, lat, pt, seen);
      exp_pt = exp_q.pop_front();
      exp_lat = lat_q.pop_front();
      first_pt = exp_pt;
      vectors++;
      if (!seen || pt !== exp_pt) begin miscompares++; $display("FAIL b2b_first_pt: got %h want %h", pt, exp_pt); end
      vectors++;
      if (lat !== exp_lat) begin miscompares++; $display("FAIL b2b_first_lat: got %0d want %0d", lat, exp_lat); end
      send(B_CT, B_KEY, B_PT);
      vectors++;
      if (decipher_busy !== 1'b1) begin miscompares++; $display("FAIL b2b_busy: got %b want 1", decipher_busy); end
      vectors++;
      if (decipher_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_ready_drop: got %b want 0", decipher_ready); end
      repeat (10) @(negedge clk);
      vectors++;
      if (plain_text !== first_pt) begin miscompares++; $display("FAIL b2b_hold: got %h want %h", plain_text, first_pt); end
      wait_ready(10, lat, pt, seen);
      exp_pt = exp_q.pop_front();
      exp_lat = lat_q.pop_front();
      vectors++;
      if (!seen || pt !== exp_pt) begin miscompares++; $display("FAIL b2b_second_pt: got %h want %h", pt, exp_pt); end
      vectors++;
      if (lat !== exp_lat) begin miscompares++; $display("FAIL b2b_second_lat: got %0d want %0d", lat, exp_lat); end
      @(negedge clk);
   endtask

   task automatic test_cache();
      int lat; logic [127:0] pt; bit seen; logic [127:0] exp_pt; int exp_lat;
      logic [127:0] cts [3];
      logic [127:0] keys [3];
      logic [127:0] pts [3];
      cts  = '{C1_CT,  C1_CT,  B_CT};
      keys = '{C1_KEY, C1_KEY, B_KEY};
      pts  = '{C1_PT,  C1_PT,  B_PT};
      for (int i = 0; i < 3; i++) begin
         send(cts[i], keys[i], pts[i]);
         wait_ready(0, lat, pt, seen);
         exp_pt = exp_q.pop_front();
         exp_lat = lat_q.pop_front();
         vectors++;
         if (!seen || pt !== exp_pt) begin miscompares++; $display("FAIL cache_pt[%0d]: got %h want %h", i, pt, exp_pt); end
         vectors++;
         if (lat !== exp_lat) begin miscompares++; $display("FAIL cache_lat[%0d]: got %0d want %0d", i, lat, exp_lat); end
         @(negedge clk);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      decipher_new_en = 1'b0;
      cipher_text = '0;
      cipher_key  = '0;
      @(negedge clk);
      test_reset();
      test_fips_c1();
      test_fips_b();
      test_busy_ignore();
      test_reset_mid_op();
      test_back_to_back();
      test_cache();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
